// File: rtl/alu_req_sequencer_if.sv
// alu_req_sequencer_if
//   Bundles the requester, ALU and response signals of alu_req_sequencer.
//
//   Handshake rule for every valid/ready pair here (req0, req1, rsp): a
//   transfer happens on a rising clk edge where valid and ready are both
//   high. The source holds valid and its payload stable until that edge.
//   ready may depend combinationally on valid, but never the other way round.
//
//   Signals:
//     req0_* / req1_*  valid, ready, a[3:0], b[3:0], op[2:0] per requester
//     alu_a, alu_b     operands to the shared combinational ALU
//     alu_sel          one-hot operation select to the ALU
//     alu_result       ALU result back to the sequencer
//     rsp_*            valid, ready, data[7:0], id for the response channel
//     busy             sequencer is not idle
//
//   Modports: slave = sequencer side, master = requesters/ALU/consumer side.
interface alu_req_sequencer_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [2:0] req0_op;

  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [2:0] req1_op;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_sel;
  logic [7:0] alu_result;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;

  logic       busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer
//   Shares one combinational 4-bit ALU between two requesters. A request is
//   accepted in IDLE (round-robin on ties), its operands are held on the ALU
//   for ALU_LAT cycles, the result is captured and then offered on the
//   response channel together with the requester id.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     bus        alu_req_sequencer_if.slave (requests, ALU, response, busy)
//     dbg_state  current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
//
//   Parameter:
//     ALU_LAT    cycles the ALU inputs are held before capture, 1..15
module alu_req_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_req_sequencer_if.slave   bus,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  logic [1:0] state;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [2:0] op_q;
  logic       id_q;
  logic       last_id;
  logic [3:0] lat_cnt;
  logic [7:0] rsp_data_q;
  logic       rsp_id_q;

  logic       grant_id;
  logic       accept;

  // With a single valid requester it wins; on a tie the one not served last
  // wins. When neither is valid grant_id is unused.
  always_comb begin
    grant_id = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_id;
    end
  end

  assign accept = (state == IDLE) && (bus.req0_valid || bus.req1_valid);

  // Ready is suppressed while reset is asserted so no requester believes it
  // was accepted in a cycle whose edge is consumed by reset.
  assign bus.req0_ready = accept && !rst && !grant_id;
  assign bus.req1_ready = accept && !rst &&  grant_id;

  // opcode 0 (add) maps to bit 7 down to opcode 7 (xor) at bit 0.
  assign bus.alu_sel = (state == ISSUE) ? (8'h80 >> op_q) : 8'h00;
  assign bus.alu_a   = (state == ISSUE) ? a_q : 4'h0;
  assign bus.alu_b   = (state == ISSUE) ? b_q : 4'h0;

  // A response visible during reset would be discarded by the same edge, so
  // it is hidden rather than offered.
  assign bus.rsp_valid = (state == RESP) && !rst;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_id    <= 1'b1;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      op_q       <= 3'd0;
      id_q       <= 1'b0;
      lat_cnt    <= 4'd0;
      rsp_data_q <= 8'h00;
      rsp_id_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= grant_id ? bus.req1_a  : bus.req0_a;
            b_q     <= grant_id ? bus.req1_b  : bus.req0_b;
            op_q    <= grant_id ? bus.req1_op : bus.req0_op;
            id_q    <= grant_id;
            last_id <= grant_id;
            lat_cnt <= LAT_INIT;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            rsp_data_q <= bus.alu_result;
            rsp_id_q   <= id_q;
            state      <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_sequencer.sv
module tb_alu_req_sequencer;

  localparam int LAT1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  alu_req_sequencer_if bus1 ();
  alu_req_sequencer_if bus3 ();
  logic [1:0] dbg1;
  logic [1:0] dbg3;

  alu_req_sequencer #(.ALU_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .dbg_state(dbg1)
  );

  alu_req_sequencer #(.ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(bus3), .dbg_state(dbg3)
  );

  // ---------------- ALU model (decodes the one-hot select) ----------------
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [7:0] sel);
    logic [7:0] r;
    case (sel)
      8'h80:   r = {4'(a + b), 4'h0};
      8'h40:   r = {4'(~a + 4'd1), 4'h0};
      8'h20:   r = {4'(~b + 4'd1), 4'h0};
      8'h10:   r = {4'(a + ~b + 4'd1), 4'h0};
      8'h08:   r = {4'h0, a} * {4'h0, b};
      8'h04:   r = {a & b, 4'h0};
      8'h02:   r = {a | b, 4'h0};
      8'h01:   r = {a ^ b, 4'h0};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb bus1.alu_result = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
  always_comb bus3.alu_result = alu_model(bus3.alu_a, bus3.alu_b, bus3.alu_sel);

  // ---------------- reference: result of an opcode ----------------
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    int v;
    case (op)
      3'd0:    v = (int'(a) + int'(b)) % 16;
      3'd1:    v = (16 - int'(a)) % 16;
      3'd2:    v = (16 - int'(b)) % 16;
      3'd3:    v = (16 + int'(a) - int'(b)) % 16;
      3'd4:    v = int'(a) * int'(b);
      3'd5:    v = int'(a & b);
      3'd6:    v = int'(a | b);
      default: v = int'(a ^ b);
    endcase
    return (op == 3'd4) ? 8'(v) : 8'(v * 16);
  endfunction

  function automatic logic pick(input logic v0, input logic v1, input logic last);
    return (v0 && v1) ? !last : v1;
  endfunction

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // ---------------- behavioural model of dut1 ----------------
  // A transaction is either absent, in its k-th issue cycle (1..LAT1), or
  // waiting for the consumer (k > LAT1).
  bit         model_on = 0;
  bit         m_busy   = 0;
  int         m_cyc    = 0;
  logic [3:0] m_a      = '0;
  logic [3:0] m_b      = '0;
  logic [2:0] m_op     = '0;
  logic       m_id     = 1'b0;
  logic       m_last   = 1'b1;
  logic [7:0] m_rsp_data = '0;
  logic       m_rsp_id   = 1'b0;
  logic [8:0] exp_q[$];

  logic       mw;
  initial forever begin
    @(posedge clk);
    if (rst1) begin
      m_busy = 0; m_last = 1'b1; m_rsp_data = '0; m_rsp_id = 1'b0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (bus1.req0_valid || bus1.req1_valid) begin
        mw     = pick(bus1.req0_valid, bus1.req1_valid, m_last);
        m_a    = mw ? bus1.req1_a  : bus1.req0_a;
        m_b    = mw ? bus1.req1_b  : bus1.req0_b;
        m_op   = mw ? bus1.req1_op : bus1.req0_op;
        m_id   = mw;
        m_last = mw;
        m_busy = 1;
        m_cyc  = 1;
        exp_q.push_back({mw, alu_ref(m_a, m_b, m_op)});
      end
    end else if (m_cyc <= LAT1) begin
      m_cyc++;
      if (m_cyc > LAT1) begin
        m_rsp_data = alu_ref(m_a, m_b, m_op);
        m_rsp_id   = m_id;
      end
    end else if (bus1.rsp_ready) begin
      m_busy = 0;
    end
  end

  // ---------------- compare process: every cycle on the falling edge --------
  logic       c_issue, c_resp, c_w;
  logic [8:0] c_exp;
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      c_issue = m_busy && (m_cyc <= LAT1);
      c_resp  = m_busy && (m_cyc >  LAT1);
      c_w     = pick(bus1.req0_valid, bus1.req1_valid, m_last);
      chk("req0_ready", bus1.req0_ready, !rst1 && !m_busy && bus1.req0_valid && !c_w);
      chk("req1_ready", bus1.req1_ready, !rst1 && !m_busy && bus1.req1_valid &&  c_w);
      chk("alu_a",   bus1.alu_a,   c_issue ? m_a : 4'h0);
      chk("alu_b",   bus1.alu_b,   c_issue ? m_b : 4'h0);
      chk("alu_sel", bus1.alu_sel, c_issue ? 8'(1 << (7 - int'(m_op))) : 8'h00);
      chk("rsp_valid", bus1.rsp_valid, c_resp && !rst1);
      chk("rsp_data",  bus1.rsp_data,  m_rsp_data);
      chk("rsp_id",    bus1.rsp_id,    m_rsp_id);
      chk("busy",      bus1.busy,      m_busy);
      chk("dbg_idle",  dbg1 != 2'd0,   m_busy);
      if (bus1.rsp_valid && bus1.rsp_ready && !rst1) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_rsp", bus1.rsp_valid, 1'b0);
        end else begin
          c_exp = exp_q.pop_front();
          chk("sb_data", bus1.rsp_data, c_exp[7:0]);
          chk("sb_id",   bus1.rsp_id,   c_exp[8]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req1(input int r, input logic v, input logic [3:0] a,
                            input logic [3:0] b, input logic [2:0] op);
    if (r == 0) begin
      bus1.req0_valid = v; bus1.req0_a = a; bus1.req0_b = b; bus1.req0_op = op;
    end else begin
      bus1.req1_valid = v; bus1.req1_a = a; bus1.req1_b = b; bus1.req1_op = op;
    end
  endtask

  task automatic rand_phase(input int n);
    logic acc0, acc1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc0 = bus1.req0_valid && bus1.req0_ready;
      acc1 = bus1.req1_valid && bus1.req1_ready;
      tick();
      if (rst1) rst1 = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst1 = 1'b1;
      if (acc0 || !bus1.req0_valid)
        drive_req1(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      else if ($urandom_range(0, 15) == 0) bus1.req0_valid = 1'b0;
      if (acc1 || !bus1.req1_valid)
        drive_req1(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      else if ($urandom_range(0, 15) == 0) bus1.req1_valid = 1'b0;
      bus1.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // ---------------- directed tests on dut1 ----------------
  task automatic test_reset_idle();
    rst1 = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_req0_ready", bus1.req0_ready, 1'b0);
    chk("rst_req1_ready", bus1.req1_ready, 1'b0);
    chk("rst_alu_a",      bus1.alu_a,      4'h0);
    chk("rst_alu_b",      bus1.alu_b,      4'h0);
    chk("rst_alu_sel",    bus1.alu_sel,    8'h00);
    chk("rst_rsp_valid",  bus1.rsp_valid,  1'b0);
    chk("rst_rsp_data",   bus1.rsp_data,   8'h00);
    chk("rst_rsp_id",     bus1.rsp_id,     1'b0);
    chk("rst_busy",       bus1.busy,       1'b0);
    model_on = 1;
    tick();
    rst1 = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_no_ready0", bus1.req0_ready, 1'b0);
    chk("idle_no_ready1", bus1.req1_ready, 1'b0);
    tick();
  endtask

  task automatic test_single_add();
    bus1.rsp_ready = 1'b1;
    drive_req1(0, 1'b1, 4'd3, 4'd5, 3'd0);
    @(negedge clk);
    chk("add_ready0", bus1.req0_ready, 1'b1);
    tick();
    bus1.req0_valid = 1'b0;
    @(negedge clk);
    chk("add_sel",       bus1.alu_sel,   8'h80);
    chk("add_rsp_early", bus1.rsp_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("add_rsp_valid", bus1.rsp_valid, 1'b1);
    chk("add_rsp_data",  bus1.rsp_data,  8'h80);
    chk("add_rsp_id",    bus1.rsp_id,    1'b0);
    tick();
    @(negedge clk);
    chk("add_busy_after", bus1.busy, 1'b0);
    tick();
  endtask

  task automatic test_mul_backpressure();
    bus1.rsp_ready = 1'b0;
    drive_req1(1, 1'b1, 4'hF, 4'hF, 3'd4);
    @(negedge clk);
    chk("mul_ready1", bus1.req1_ready, 1'b1);
    tick();
    bus1.req1_valid = 1'b0;
    drive_req1(0, 1'b1, 4'd1, 4'd2, 3'd6);
    @(negedge clk);
    chk("mul_issue_ready0", bus1.req0_ready, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mul_hold_valid",  bus1.rsp_valid,  1'b1);
      chk("mul_hold_data",   bus1.rsp_data,   8'hE1);
      chk("mul_hold_id",     bus1.rsp_id,     1'b1);
      chk("mul_hold_ready0", bus1.req0_ready, 1'b0);
      tick();
    end
    bus1.rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("mul_after_ready0", bus1.req0_ready, 1'b1);
    tick();
    bus1.req0_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_contention();
    logic b_q[$];
    logic r_q[$];
    logic acc0, acc1;
    logic [3:0] exp_seq;
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    bus1.rsp_ready = 1'b1;
    drive_req1(0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    drive_req1(1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    for (int c = 0; c < 100 && (b_q.size() < 4 || r_q.size() < 4); c++) begin
      @(negedge clk);
      acc0 = bus1.req0_valid && bus1.req0_ready;
      acc1 = bus1.req1_valid && bus1.req1_ready;
      if (acc0) b_q.push_back(1'b0);
      if (acc1) b_q.push_back(1'b1);
      if (bus1.rsp_valid && bus1.rsp_ready) r_q.push_back(bus1.rsp_id);
      tick();
      if (b_q.size() >= 4) begin
        bus1.req0_valid = 1'b0;
        bus1.req1_valid = 1'b0;
      end else begin
        if (acc0) drive_req1(0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        if (acc1) drive_req1(1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      end
    end
    chk("cont_grant_count", b_q.size() >= 4, 1'b1);
    chk("cont_rsp_count",   r_q.size() >= 4, 1'b1);
    exp_seq = 4'b1010;  // bit i = id of i-th grant: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      if (i < b_q.size()) chk("cont_grant_order", b_q[i], exp_seq[i]);
      if (i < r_q.size()) chk("cont_rsp_id_order", r_q[i], exp_seq[i]);
    end
    tick();
  endtask

  // ---------------- directed tests on dut3 (ALU_LAT = 3) ----------------
  task automatic test_lat3();
    int seen;
    rst3 = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("l3_rst_busy",  bus3.busy,      1'b0);
    chk("l3_rst_sel",   bus3.alu_sel,   8'h00);
    chk("l3_rst_valid", bus3.rsp_valid, 1'b0);
    chk("l3_rst_data",  bus3.rsp_data,  8'h00);
    chk("l3_rst_dbg",   dbg3,           2'd0);
    tick();
    rst3 = 1'b0;
    bus3.rsp_ready = 1'b1;
    bus3.req0_valid = 1'b1; bus3.req0_a = 4'd2; bus3.req0_b = 4'd5; bus3.req0_op = 3'd3;
    @(negedge clk);
    chk("l3_sub_ready0", bus3.req0_ready, 1'b1);
    tick();
    bus3.req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l3_sub_sel_held", bus3.alu_sel,   8'h10);
      chk("l3_sub_a_held",   bus3.alu_a,     4'd2);
      chk("l3_sub_no_rsp",   bus3.rsp_valid, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("l3_sub_sel_off",   bus3.alu_sel,   8'h00);
    chk("l3_sub_rsp_valid", bus3.rsp_valid, 1'b1);
    chk("l3_sub_rsp_data",  bus3.rsp_data,  8'hD0);
    chk("l3_sub_rsp_id",    bus3.rsp_id,    1'b0);
    tick();
    @(negedge clk);
    chk("l3_sub_done", bus3.busy, 1'b0);
    tick();
    // reset during the second issue cycle of a req0 operation
    bus3.req0_valid = 1'b1; bus3.req0_a = 4'd1; bus3.req0_b = 4'd1; bus3.req0_op = 3'd0;
    @(negedge clk);
    chk("l3_mid_ready0", bus3.req0_ready, 1'b1);
    tick();
    bus3.req0_valid = 1'b0;
    @(negedge clk);
    chk("l3_mid_issue1", bus3.alu_sel, 8'h80);
    tick();
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus3.rsp_valid) seen++;
      tick();
    end
    chk("l3_mid_no_rsp", seen, 0);
    chk("l3_mid_idle",   bus3.busy, 1'b0);
    bus3.req0_valid = 1'b1; bus3.req1_valid = 1'b1;
    bus3.req1_a = 4'd7; bus3.req1_b = 4'd1; bus3.req1_op = 3'd7;
    @(negedge clk);
    chk("l3_tie_ready0", bus3.req0_ready, 1'b1);
    chk("l3_tie_ready1", bus3.req1_ready, 1'b0);
    tick();
    bus3.req0_valid = 1'b0; bus3.req1_valid = 1'b0;
    repeat (6) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    drive_req1(0, 1'b0, 4'h0, 4'h0, 3'd0);
    drive_req1(1, 1'b0, 4'h0, 4'h0, 3'd0);
    bus1.rsp_ready = 1'b0;
    bus3.req0_valid = 1'b0; bus3.req0_a = '0; bus3.req0_b = '0; bus3.req0_op = '0;
    bus3.req1_valid = 1'b0; bus3.req1_a = '0; bus3.req1_b = '0; bus3.req1_op = '0;
    bus3.rsp_ready = 1'b0;
    #1;
    test_reset_idle();
    test_single_add();
    test_mul_backpressure();
    test_contention();
    rand_phase(1500);
    rst1 = 1'b0;
    drive_req1(0, 1'b0, 4'h0, 4'h0, 3'd0);
    drive_req1(1, 1'b0, 4'h0, 4'h0, 3'd0);
    bus1.rsp_ready = 1'b1;
    repeat (10) tick();
    chk("final_sb_empty", exp_q.size(), 0);
    test_lat3();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_req_sequencer.md
Name: alu_req_sequencer

Overview:
- Sequences a shared combinational 4-bit ALU between two requesters.
- The ALU operates on operands A and B and provides add, negate A, negate B, subtract, multiply (8-bit result), AND, OR and XOR.
- Each requester presents operands and a 3-bit opcode over a valid/ready handshake. The block round-robin arbitrates, drives the ALU with registered operands and a one-hot select, holds the select for ALU_LAT cycles, captures the result, and returns it with the requester ID over a valid/ready response channel.

Parameters:
- ALU_LAT, 1, cycles the ALU inputs are held stable before the result is captured; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset. Named rst; the _n suffix is reserved for active-low resets.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0's operation is accepted this cycle.
- req0_a  input  4  operand A, requester 0.
- req0_b  input  4  operand B, requester 0.
- req0_op  input  3  opcode, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as the requester 0 ports, for requester 1.
- alu_a  output  4  operand A to the ALU.
- alu_b  output  4  operand B to the ALU.
- alu_sel  output  8  one-hot ALU select: bit7 add, bit6 negA, bit5 negB, bit4 sub, bit3 mul, bit2 and, bit1 or, bit0 xor.
- alu_result  input  8  ALU result. 4-bit operations arrive in [7:4] with [3:0]=0; multiply uses [7:0].
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  8  captured ALU result.
- rsp_id  output  1  ID of the requester the response belongs to.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Opcode map: 0 add, 1 negA, 2 negB, 3 sub, 4 mul, 5 and, 6 or, 7 xor. alu_sel = 8'b1 << (7-op), so exactly one bit is set during ISSUE.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - If either reqN_valid is high, grant one requester.
  - reqN_ready is combinational: asserted only in IDLE, only for the granted requester, in the same cycle as its valid.
  - On the accepting edge: latch a, b, op and id into internal registers, set last_id=id, load lat_cnt=ALU_LAT-1, go to ISSUE.
  - No valid: stay in IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester that is not last_id.
  - last_id resets to 1, so requester 0 wins the first tie.
  - Strict alternation under continuous contention; no starvation.
- ISSUE:
  - alu_a, alu_b and alu_sel are driven from the latched registers and are stable for exactly ALU_LAT cycles.
  - While lat_cnt != 0: decrement lat_cnt and stay in ISSUE.
  - When lat_cnt == 0: capture alu_result into rsp_data and the latched id into rsp_id, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held constant until accepted.
  - rsp_valid && rsp_ready: go to IDLE. A new request can be accepted in the cycle after the response is taken.
  - rsp_ready is ignored outside RESP.
- Outside ISSUE: alu_sel=0, alu_a=0, alu_b=0.
- Timing:
  - Accept on edge T; ISSUE in cycles T+1..T+ALU_LAT; rsp_valid first high in cycle T+ALU_LAT+1.
  - Best-case throughput is one operation per ALU_LAT+2 cycles with rsp_ready tied high.
- Requests arriving outside IDLE are not accepted (ready=0) and must be held by the requester. A valid deasserted before acceptance is dropped without side effects.
- Reset:
  - Forces IDLE and last_id=1.
  - All outputs go to 0: rsp_valid, rsp_data, rsp_id, busy, both readys, alu_a, alu_b, alu_sel.
  - An in-flight operation or pending response is discarded, with no response emitted.
  - Reset takes priority over every other event in the same cycle, including a simultaneous valid or rsp_ready.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0 and busy=0; no ready is asserted while both valids are 0.
- Single add, ALU_LAT=1, model ALU: req0 a=3, b=5, op=0 accepted at T -> alu_sel=8'h80 at T+1; rsp_valid at T+2 with rsp_data=8'h80, rsp_id=0; busy=0 after rsp_ready.
- Multiply with backpressure: req1 a=4'hF, b=4'hF, op=4, rsp_ready held low 5 cycles -> rsp_data=8'hE1 and rsp_id=1 stable throughout; req0_ready stays 0 until the response is taken.
- Contention: both valid continuously, 4 operations -> grants in order 0,1,0,1; rsp_id sequence matches.
- ALU_LAT=3: sub a=2, b=5 -> alu_sel=8'h10 held exactly 3 cycles; rsp_data=8'hD0 at T+4.
- Reset mid-operation: assert rst in the second ISSUE cycle -> no rsp_valid ever emitted; the next tie is granted to requester 0.
